// File: rtl/atm_keypad_frontend.sv
// ATM keypad front end: assembles account, PIN, operation, amount and new PIN
// from a key strobe stream and hands one complete transaction downstream.
//
//   state   | meaning
//   IDLE  0 | no session; first digit opens ACC (unless locked)
//   ACC   1 | entering account number (1..10, up to 2 digits)
//   PIN   2 | entering 4-digit PIN
//   OPSEL 3 | single digit picks the operation
//   AMT   4 | entering amount (up to 5 digits, nonzero)
//   NPIN  5 | entering 4-digit new PIN (must differ from PIN)
//   ISSUE 6 | txn_valid pulse, fields frozen
//   WAIT  7 | waiting for atm_done, fields frozen
module atm_keypad_frontend #(
  parameter int MAX_FAILS = 3,
  parameter int TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        atm_done,
  input  logic        atm_auth_fail,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [15:0] new_pin,
  output logic [31:0] amount,
  output logic [2:0]  operation,
  output logic        txn_valid,
  output logic [2:0]  phase,
  output logic        entry_err,
  output logic        locked
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACC   = 3'd1;
  localparam logic [2:0] S_PIN   = 3'd2;
  localparam logic [2:0] S_OPSEL = 3'd3;
  localparam logic [2:0] S_AMT   = 3'd4;
  localparam logic [2:0] S_NPIN  = 3'd5;
  localparam logic [2:0] S_ISSUE = 3'd6;
  localparam logic [2:0] S_WAIT  = 3'd7;

  localparam logic [3:0] K_BACK   = 4'd10;
  localparam logic [3:0] K_ENTER  = 4'd11;
  localparam logic [3:0] K_CANCEL = 4'd12;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);

  logic [2:0]    state, state_n;
  // account held 7 bits wide so a two-digit entry like 11 is seen and rejected
  logic [6:0]    acc_q, acc_n;
  logic [1:0]    acc_cnt, acc_cnt_n;
  logic [15:0]   pin_q, pin_n, npin_q, npin_n;
  logic [2:0]    pin_cnt, pin_cnt_n, npin_cnt, npin_cnt_n;
  logic [31:0]   amt_q, amt_n;
  logic [2:0]    amt_cnt, amt_cnt_n;
  logic [2:0]    op_q, op_n;
  logic [FW-1:0] fail_cnt, fail_n;
  logic          lock_q, lock_n;
  logic          err_q, err_n;
  logic [TW-1:0] tmr;
  logic          clr, is_digit, tmr_active, timeout;

  assign is_digit   = (key_code <= 4'd9);
  assign tmr_active = (state >= S_ACC) && (state <= S_NPIN);
  // a key in the expiry cycle wins over the timeout
  assign timeout    = tmr_active && !key_valid && (tmr == '0);

  always_comb begin
    state_n    = state;
    acc_n      = acc_q;
    acc_cnt_n  = acc_cnt;
    pin_n      = pin_q;
    pin_cnt_n  = pin_cnt;
    amt_n      = amt_q;
    amt_cnt_n  = amt_cnt;
    npin_n     = npin_q;
    npin_cnt_n = npin_cnt;
    op_n       = op_q;
    fail_n     = fail_cnt;
    lock_n     = lock_q;
    err_n      = 1'b0;
    clr        = 1'b0;
    case (state)
      S_IDLE: if (key_valid && is_digit) begin
        if (lock_q) err_n = 1'b1;
        else begin
          state_n   = S_ACC;
          acc_n     = {3'b000, key_code};
          acc_cnt_n = 2'd1;
        end
      end
      S_ACC: if (key_valid) begin
        if (is_digit) begin
          if (acc_cnt == 2'd2) err_n = 1'b1;
          else begin
            acc_n     = acc_q * 7'd10 + {3'b000, key_code};
            acc_cnt_n = acc_cnt + 2'd1;
          end
        end else if (key_code == K_BACK) begin
          if (acc_cnt != 2'd0) begin
            acc_n     = acc_q / 7'd10;
            acc_cnt_n = acc_cnt - 2'd1;
          end
        end else if (key_code == K_ENTER) begin
          if (acc_q >= 7'd1 && acc_q <= 7'd10) state_n = S_PIN;
          else begin
            err_n     = 1'b1;
            acc_n     = '0;
            acc_cnt_n = '0;
          end
        end else if (key_code == K_CANCEL) clr = 1'b1;
      end
      S_PIN: if (key_valid) begin
        if (is_digit) begin
          if (pin_cnt == 3'd4) err_n = 1'b1;
          else begin
            pin_n     = pin_q * 16'd10 + {12'd0, key_code};
            pin_cnt_n = pin_cnt + 3'd1;
          end
        end else if (key_code == K_BACK) begin
          if (pin_cnt != 3'd0) begin
            pin_n     = pin_q / 16'd10;
            pin_cnt_n = pin_cnt - 3'd1;
          end
        end else if (key_code == K_ENTER) begin
          if (pin_cnt == 3'd4) state_n = S_OPSEL;
          else err_n = 1'b1;
        end else if (key_code == K_CANCEL) clr = 1'b1;
      end
      S_OPSEL: if (key_valid) begin
        if (is_digit) begin
          case (key_code)
            4'd3:       begin op_n = key_code[2:0]; state_n = S_ISSUE; end
            4'd4, 4'd5: begin op_n = key_code[2:0]; state_n = S_AMT;   end
            4'd6:       begin op_n = key_code[2:0]; state_n = S_NPIN;  end
            default:    err_n = 1'b1;
          endcase
        end else if (key_code == K_BACK) state_n = S_PIN;
        else if (key_code == K_CANCEL) clr = 1'b1;
      end
      S_AMT: if (key_valid) begin
        if (is_digit) begin
          if (amt_cnt == 3'd5) err_n = 1'b1;
          else begin
            amt_n     = amt_q * 32'd10 + {28'd0, key_code};
            amt_cnt_n = amt_cnt + 3'd1;
          end
        end else if (key_code == K_BACK) begin
          if (amt_cnt != 3'd0) begin
            amt_n     = amt_q / 32'd10;
            amt_cnt_n = amt_cnt - 3'd1;
          end
        end else if (key_code == K_ENTER) begin
          if (amt_cnt != 3'd0 && amt_q != 32'd0) state_n = S_ISSUE;
          else err_n = 1'b1;
        end else if (key_code == K_CANCEL) clr = 1'b1;
      end
      S_NPIN: if (key_valid) begin
        if (is_digit) begin
          if (npin_cnt == 3'd4) err_n = 1'b1;
          else begin
            npin_n     = npin_q * 16'd10 + {12'd0, key_code};
            npin_cnt_n = npin_cnt + 3'd1;
          end
        end else if (key_code == K_BACK) begin
          if (npin_cnt != 3'd0) begin
            npin_n     = npin_q / 16'd10;
            npin_cnt_n = npin_cnt - 3'd1;
          end
        end else if (key_code == K_ENTER) begin
          if (npin_cnt == 3'd4 && npin_q != pin_q) state_n = S_ISSUE;
          else begin
            err_n      = 1'b1;
            npin_n     = '0;
            npin_cnt_n = '0;
          end
        end else if (key_code == K_CANCEL) clr = 1'b1;
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: if (atm_done) begin
        clr = 1'b1;
        if (atm_auth_fail) begin
          fail_n = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;
          if (fail_n == FAIL_MAX) lock_n = 1'b1;
        end else begin
          fail_n = '0;
        end
      end
    endcase
    if (timeout) begin
      clr   = 1'b1;
      err_n = 1'b1;
    end
    if (clr) begin
      state_n    = S_IDLE;
      acc_n      = '0;
      acc_cnt_n  = '0;
      pin_n      = '0;
      pin_cnt_n  = '0;
      amt_n      = '0;
      amt_cnt_n  = '0;
      npin_n     = '0;
      npin_cnt_n = '0;
      op_n       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      acc_q    <= '0;
      acc_cnt  <= '0;
      pin_q    <= '0;
      pin_cnt  <= '0;
      amt_q    <= '0;
      amt_cnt  <= '0;
      npin_q   <= '0;
      npin_cnt <= '0;
      op_q     <= '0;
      fail_cnt <= '0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
      tmr      <= '0;
    end else begin
      state    <= state_n;
      acc_q    <= acc_n;
      acc_cnt  <= acc_cnt_n;
      pin_q    <= pin_n;
      pin_cnt  <= pin_cnt_n;
      amt_q    <= amt_n;
      amt_cnt  <= amt_cnt_n;
      npin_q   <= npin_n;
      npin_cnt <= npin_cnt_n;
      op_q     <= op_n;
      fail_cnt <= fail_n;
      lock_q   <= lock_n;
      err_q    <= err_n;
      if (key_valid || state_n != state) tmr <= TMR_LOAD;
      else if (tmr_active && tmr != '0) tmr <= tmr - 1'b1;
    end
  end

  assign acc_num   = acc_q[3:0];
  assign pin       = pin_q;
  assign new_pin   = npin_q;
  assign amount    = amt_q;
  assign operation = op_q;
  assign txn_valid = (state == S_ISSUE);
  assign phase     = state;
  assign entry_err = err_q;
  assign locked    = lock_q;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Directed bench for atm_keypad_frontend; issued transactions are checked
// against a queue of expected field sets pushed as each session is keyed in.
module tb_atm_keypad_frontend;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'hF;
  logic        atm_done = 1'b0;
  logic        atm_auth_fail = 1'b0;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [15:0] new_pin;
  logic [31:0] amount;
  logic [2:0]  operation;
  logic        txn_valid;
  logic [2:0]  phase;
  logic        entry_err;
  logic        locked;

  always #5 clk = ~clk;

  atm_keypad_frontend #(.MAX_FAILS(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .atm_done(atm_done), .atm_auth_fail(atm_auth_fail),
    .acc_num(acc_num), .pin(pin), .new_pin(new_pin), .amount(amount),
    .operation(operation), .txn_valid(txn_valid), .phase(phase),
    .entry_err(entry_err), .locked(locked)
  );

  typedef struct {
    logic [3:0]  acc;
    logic [15:0] pin;
    logic [15:0] npin;
    logic [31:0] amt;
    logic [2:0]  op;
  } txn_t;

  txn_t exp_q[$];
  txn_t got;
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_txn(input logic [3:0] a, input logic [15:0] p, input logic [15:0] n,
                            input logic [31:0] m, input logic [2:0] o);
    txn_t t;
    t.acc = a; t.pin = p; t.npin = n; t.amt = m; t.op = o;
    exp_q.push_back(t);
  endtask

  task automatic press(input logic [3:0] code);
    @(negedge clk); key_valid = 1'b1; key_code = code;
    @(negedge clk); key_valid = 1'b0; key_code = 4'hF;
  endtask

  // keys packed as hex nibbles, first key in the most significant used nibble
  task automatic keys(input logic [63:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) press(s[4*i +: 4]);
  endtask

  task automatic done(input logic fail);
    @(negedge clk); atm_done = 1'b1; atm_auth_fail = fail;
    @(negedge clk); atm_done = 1'b0; atm_auth_fail = 1'b0;
  endtask

  task automatic session(input logic fail);
    expect_txn(4'd1, 16'd1234, 16'd0, 32'd0, 3'd3);
    keys(64'h1B1234B3, 8);
    done(fail);
  endtask

  always @(negedge clk) begin
    if (txn_valid === 1'b1) begin
      if (exp_q.size() == 0) check("txn_unexpected", 32'(txn_valid), 0);
      else begin
        got = exp_q.pop_front();
        check("txn_acc", 32'(acc_num), 32'(got.acc));
        check("txn_pin", 32'(pin), 32'(got.pin));
        check("txn_new_pin", 32'(new_pin), 32'(got.npin));
        check("txn_amount", amount, got.amt);
        check("txn_op", 32'(operation), 32'(got.op));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_phase", 32'(phase), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_txn", 32'(txn_valid), 0);
    check("rst_err", 32'(entry_err), 0);
    check("rst_pin", 32'(pin), 0);
    check("rst_amount", amount, 0);
    rst = 1'b0;

    // balance enquiry
    expect_txn(4'd1, 16'd1234, 16'd0, 32'd0, 3'd3);
    keys(64'h1B1234B3, 8);
    check("bal_phase_issue", 32'(phase), 6);
    check("bal_txn_high", 32'(txn_valid), 1);
    @(negedge clk);
    check("bal_phase_wait", 32'(phase), 7);
    check("bal_txn_low", 32'(txn_valid), 0);
    press(4'hC);
    check("wait_cancel_ignored", 32'(phase), 7);
    check("wait_hold_acc", 32'(acc_num), 1);
    check("wait_hold_pin", 32'(pin), 1234);
    done(1'b0);
    check("done_phase", 32'(phase), 0);
    check("done_acc", 32'(acc_num), 0);
    check("done_pin", 32'(pin), 0);
    check("done_op", 32'(operation), 0);

    // withdrawal of 500
    expect_txn(4'd2, 16'd2345, 16'd0, 32'd500, 3'd4);
    keys(64'h2B2345B4500B, 12);
    check("wd_phase_issue", 32'(phase), 6);
    done(1'b0);
    check("wd_done_phase", 32'(phase), 0);
    check("wd_done_amount", amount, 0);

    // account range, digit limits and BACK editing
    keys(64'h11B, 3);
    check("acc11_err", 32'(entry_err), 1);
    check("acc11_phase", 32'(phase), 1);
    check("acc11_cleared", 32'(acc_num), 0);
    @(negedge clk);
    check("err_one_cycle", 32'(entry_err), 0);
    keys(64'h123, 3);
    check("acc_third_digit_err", 32'(entry_err), 1);
    check("acc_third_digit_dropped", 32'(acc_num), 12);
    keys(64'hAAA, 3);
    check("acc_back_floor", 32'(acc_num), 0);
    check("acc_back_phase", 32'(phase), 1);
    keys(64'h5B, 2);
    check("acc5_to_pin", 32'(phase), 2);
    keys(64'h123B, 4);
    check("pin3_err", 32'(entry_err), 1);
    check("pin3_stay", 32'(phase), 2);
    check("pin3_value", 32'(pin), 123);
    keys(64'h4B, 2);
    check("pin_to_opsel", 32'(phase), 3);
    press(4'hA);
    check("opsel_back", 32'(phase), 2);
    check("opsel_back_pin", 32'(pin), 1234);
    press(4'hB);
    check("pin_intact_enter", 32'(phase), 3);
    press(4'h7);
    check("opsel_bad_err", 32'(entry_err), 1);
    check("opsel_bad_stay", 32'(phase), 3);
    press(4'h6);
    check("op6_phase", 32'(phase), 5);
    keys(64'h1234B, 5);
    check("npin_same_err", 32'(entry_err), 1);
    check("npin_same_cleared", 32'(new_pin), 0);
    check("npin_same_stay", 32'(phase), 5);
    expect_txn(4'd5, 16'd1234, 16'd4321, 32'd0, 3'd6);
    keys(64'h4321B, 5);
    check("npin_issue", 32'(phase), 6);
    done(1'b0);

    // cancel mid-session
    keys(64'h3B12C, 5);
    check("cancel_phase", 32'(phase), 0);
    check("cancel_acc", 32'(acc_num), 0);
    check("cancel_pin", 32'(pin), 0);

    // inactivity timeout in PIN
    keys(64'h1B, 2);
    repeat (7) @(negedge clk);
    check("tmo_not_yet", 32'(phase), 2);
    @(negedge clk);
    check("tmo_phase", 32'(phase), 0);
    check("tmo_err", 32'(entry_err), 1);

    // key on the expiry cycle wins and restarts the timer
    keys(64'h1B, 2);
    repeat (6) @(negedge clk);
    press(4'h5);
    check("tmo_key_phase", 32'(phase), 2);
    check("tmo_key_no_err", 32'(entry_err), 0);
    check("tmo_key_pin", 32'(pin), 5);
    repeat (7) @(negedge clk);
    check("tmo_restart_not_yet", 32'(phase), 2);
    @(negedge clk);
    check("tmo_restart_phase", 32'(phase), 0);

    // lockout after three failures; stray atm_done in IDLE ignored
    session(1'b1);
    session(1'b1);
    check("lock_after2", 32'(locked), 0);
    done(1'b1);
    check("idle_done_ignored", 32'(locked), 0);
    session(1'b1);
    check("lock_after3", 32'(locked), 1);
    press(4'h1);
    check("locked_digit_err", 32'(entry_err), 1);
    check("locked_phase", 32'(phase), 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_unlocks", 32'(locked), 0);

    // a successful session clears the fail counter
    for (int i = 0; i < 5; i++) begin
      session(i != 2);
      check("fail_cnt_cleared", 32'(locked), 0);
    end
    session(1'b1);
    check("lock_after_clear", 32'(locked), 1);

    // rst beats a same-cycle key
    @(negedge clk); rst = 1'b1; key_valid = 1'b1; key_code = 4'h1;
    @(negedge clk); rst = 1'b0; key_valid = 1'b0; key_code = 4'hF;
    check("rst_over_key_phase", 32'(phase), 0);
    check("rst_over_key_locked", 32'(locked), 0);

    // rst during WAIT abandons the transaction
    expect_txn(4'd1, 16'd1234, 16'd0, 32'd0, 3'd3);
    keys(64'h1B1234B3, 8);
    @(negedge clk);
    check("pre_rst_wait", 32'(phase), 7);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_wait_phase", 32'(phase), 0);
    check("rst_wait_acc", 32'(acc_num), 0);
    done(1'b1);
    check("late_done_phase", 32'(phase), 0);
    press(4'h2);
    check("after_rst_session", 32'(phase), 1);
    check("after_rst_acc", 32'(acc_num), 2);
    press(4'hC);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
